mini_ex_core_fetch: RTL and testbench
=====================================

Name: mini_ex_core_fetch

Overview:
- Instruction-fetch stage of the mini execution core. Sits directly upstream of decode/controller.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents the instruction, its PC and the split instruction fields to decode in Q101H.
- Handles decode back-pressure (stall) and jump/branch redirects without losing or duplicating instructions.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction word.
- PC_RESET, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- Clk  in  1  core clock.
- Rst  in  1  synchronous, active-high reset.
- StallQ101H  in  1  decode cannot accept the presented instruction; hold outputs.
- JmpEnableQ101H  in  1  redirect request from execute.
- JmpTargetQ101H  in  DATA_WIDTH  redirect target address.
- ImemRdEnQ100H  out  1  instruction memory read enable.
- ImemAddrQ100H  out  DATA_WIDTH  instruction memory byte address.
- ImemRdDataQ101H  in  DATA_WIDTH  memory data, valid the cycle after ImemRdEnQ100H.
- InstrValidQ101H  out  1  presented instruction is real.
- InstrQ101H  out  DATA_WIDTH  instruction word; NOP (32'h0000_0013) when invalid.
- PcQ101H  out  DATA_WIDTH  address of the presented instruction.
- InstrFieldsQ101H  out  t_instr_fields  opcode/rd/func3/rs1/rs2/func7 sliced from InstrQ101H.

Behaviour:
- One clock (Clk). Reset Rst is synchronous and active-high.
- States: S_IDLE (no read outstanding), S_RUN (read outstanding, data on ImemRdDataQ101H), S_HOLD (instruction parked in hold register).
- Reset values:
  - PC = PC_RESET; state = S_IDLE.
  - InstrValidQ101H = 0; InstrQ101H = NOP; PcQ101H = 0.
  - Hold register = NOP.
  - ImemRdEnQ100H = 0 during the reset cycle.
- Reset mid-operation: the outstanding read and the hold contents are discarded.
- S_IDLE: issue read of PC (ImemRdEnQ100H=1, ImemAddrQ100H=PC); PC <= PC+4; go S_RUN. Outputs invalid.
- S_RUN:
  - Outputs: InstrQ101H = ImemRdDataQ101H; PcQ101H = registered address of the read; InstrValidQ101H = 1.
  - If !StallQ101H: issue the next read, PC += 4, stay in S_RUN. Throughput is 1 instr/cycle.
  - If StallQ101H: no read issued; copy data and PC into the hold register; go S_HOLD.
- S_HOLD:
  - Outputs come from the hold register, valid = 1.
  - While stalled: no reads issued.
  - When stall deasserts: the held instruction is consumed that cycle, the read of PC is issued, go S_RUN. This adds no bubble.
- Redirect (JmpEnableQ101H=1) has the highest priority, over stall, in any state:
  - InstrValidQ101H = 0 that cycle; the presented instruction is killed.
  - Read of JmpTargetQ101H issued the same cycle (ImemAddrQ100H = target); PC <= target+4.
  - Hold register cleared; next state S_RUN.
  - First target instruction is valid the next cycle. Redirect penalty is 0 extra bubbles beyond the killed slot.
- Alignment: target bits [1:0] are forced to 0 before use.
- Arithmetic: PC+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC+4 = 0), with no flag.
- Field slicing is purely combinational from InstrQ101H using RISC-V bit positions:
  - opcode [6:0], rd [11:7], func3 [14:12], rs1 [19:15], rs2 [24:20], func7 [31:25].

Optional Feature:
- Macro: MINI_EX_CORE_FETCH_MISALIGN_CHK_EN.
- When defined:
  - Adds output port MisalignQ101H (1 bit).
  - Set for one cycle when JmpEnableQ101H is asserted with JmpTargetQ101H[1:0] != 0.
  - Additionally sets sticky bit MisalignStickyQ101H, cleared only by Rst.
  - Redirect still proceeds with the aligned address.
- When undefined: no ports, no logic; low bits are silently masked.

Decomposition:
- Shared package (mini_ex_core_pkg) gets:
  - t_fetch_state enum {S_IDLE, S_RUN, S_HOLD}.
  - INSTR_NOP = 32'h0000_0013.
  - PC_STEP = 4.
  - Reuse of existing t_instr_fields.
- Sub-module mini_ex_core_fetch_hold: hold register plus valid bit, with load/clear/select controls; outputs the muxed instruction and PC.

Test Plan:
- Reset, PC_RESET=0, no stall: ImemAddr 0,4,8,C on successive cycles; InstrValid rises cycle 2; PcQ101H 0,4,8 in order.
- Stall 3 cycles while presenting PC=8 instr 32'h00500093: outputs stay 0x00500093/PC 8 for all 3 cycles; ImemRdEn=0; next valid instr after release is PC C.
- Jump to 0x100 while PC=0x10 is presented: valid=0 that cycle; ImemAddr=0x100 same cycle; next cycle PcQ101H=0x100, valid=1.
- Jump and stall in the same cycle, while in S_HOLD: redirect wins; hold cleared; PcQ101H=target next cycle; no stale held instruction ever reappears.
- PC=0xFFFF_FFFC fetch: next ImemAddr=0; assert Rst mid-stream: next cycle valid=0, PC restarts at PC_RESET.
- Macro on, jump to 0x102: MisalignQ101H pulses 1 cycle, sticky bit set, ImemAddr=0x100; sticky bit cleared only after Rst.

Source files
------------

// File: rtl/mini_ex_core_pkg.sv
// Shared types and constants for the mini execution core.
// Fetch states, NOP encoding, PC step and instruction field layout.
package mini_ex_core_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } t_fetch_state;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } t_instr_fields;

  function automatic t_instr_fields split_instr(input logic [31:0] i_instr);
    return t_instr_fields'(i_instr);
  endfunction

endpackage

// File: rtl/mini_ex_core_fetch_hold.sv
// Parking register for an instruction that decode could not accept.
// Selecting it replaces the memory data/PC with the parked copy.
module mini_ex_core_fetch_hold
  import mini_ex_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_mem_instr,
  input  logic [DATA_WIDTH-1:0] i_mem_pc,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_vld
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_vld;
  logic                  w_use;

  always_ff @(posedge Clk) begin
    if (Rst || i_clear) begin
      r_instr <= DATA_WIDTH'(INSTR_NOP);
      r_pc    <= '0;
      r_vld   <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_mem_instr;
      r_pc    <= i_mem_pc;
      r_vld   <= 1'b1;
    end
  end

  assign w_use   = i_sel & r_vld;
  assign o_instr = w_use ? r_instr : i_mem_instr;
  assign o_pc    = w_use ? r_pc : i_mem_pc;
  assign o_vld   = r_vld;

endmodule

// File: rtl/mini_ex_core_fetch.sv
// Instruction fetch stage: PC, imem request, stall hold and redirect.
// Optional misaligned-target flag: define MINI_EX_CORE_FETCH_MISALIGN_CHK_EN.
module mini_ex_core_fetch
  import mini_ex_core_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  StallQ101H,
  input  logic                  JmpEnableQ101H,
  input  logic [DATA_WIDTH-1:0] JmpTargetQ101H,
  output logic                  ImemRdEnQ100H,
  output logic [DATA_WIDTH-1:0] ImemAddrQ100H,
  input  logic [DATA_WIDTH-1:0] ImemRdDataQ101H,
  output logic                  InstrValidQ101H,
  output logic [DATA_WIDTH-1:0] InstrQ101H,
  output logic [DATA_WIDTH-1:0] PcQ101H,
  output t_instr_fields         InstrFieldsQ101H
`ifdef MINI_EX_CORE_FETCH_MISALIGN_CHK_EN
  ,
  output logic                  MisalignQ101H,
  output logic                  MisalignStickyQ101H
`endif
);

  t_fetch_state          r_state;
  t_fetch_state          w_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rd_pc;
  logic [DATA_WIDTH-1:0] w_tgt;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_instr;
  logic [DATA_WIDTH-1:0] w_pc;
  logic                  w_issue;
  logic                  w_load;
  logic                  w_clear;
  logic                  w_hold_vld;
  logic                  w_valid;

  assign w_tgt = JmpTargetQ101H & ~DATA_WIDTH'(3);

  always_comb begin
    w_issue = 1'b0;
    w_addr  = r_pc;
    w_load  = 1'b0;
    w_clear = 1'b0;
    w_next  = r_state;
    if (Rst) begin
      w_next = S_IDLE;
    end else if (JmpEnableQ101H) begin
      w_issue = 1'b1;
      w_addr  = w_tgt;
      w_clear = 1'b1;
      w_next  = S_RUN;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_issue = 1'b1;
          w_next  = S_RUN;
        end
        S_RUN: begin
          if (StallQ101H) begin
            w_load = 1'b1;
            w_next = S_HOLD;
          end else begin
            w_issue = 1'b1;
          end
        end
        S_HOLD: begin
          if (!StallQ101H) begin
            w_issue = 1'b1;
            w_clear = 1'b1;
            w_next  = S_RUN;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
      r_rd_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_pc    <= w_addr + DATA_WIDTH'(PC_STEP);
        r_rd_pc <= w_addr;
      end
    end
  end

  mini_ex_core_fetch_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_sel      (r_state == S_HOLD),
    .i_mem_instr(ImemRdDataQ101H),
    .i_mem_pc   (r_rd_pc),
    .o_instr    (w_instr),
    .o_pc       (w_pc),
    .o_vld      (w_hold_vld)
  );

  // a redirect kills whatever is presented this cycle
  assign w_valid = !Rst && !JmpEnableQ101H &&
                   ((r_state == S_RUN) ||
                    ((r_state == S_HOLD) && w_hold_vld));

  assign ImemRdEnQ100H    = w_issue;
  assign ImemAddrQ100H    = w_addr;
  assign InstrValidQ101H  = w_valid;
  assign InstrQ101H       = w_valid ? w_instr : DATA_WIDTH'(INSTR_NOP);
  assign PcQ101H          = w_pc;
  assign InstrFieldsQ101H = split_instr(InstrQ101H[31:0]);

`ifdef MINI_EX_CORE_FETCH_MISALIGN_CHK_EN
  logic r_sticky;
  logic w_mis;

  assign w_mis = !Rst && JmpEnableQ101H && (JmpTargetQ101H[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sticky <= 1'b0;
    end else if (w_mis) begin
      r_sticky <= 1'b1;
    end
  end

  assign MisalignQ101H       = w_mis;
  assign MisalignStickyQ101H = r_sticky;
`endif

endmodule

// File: tb/tb_mini_ex_core_fetch.sv
// Directed bench for mini_ex_core_fetch with a 1-cycle imem model.
// Misalign checks are compiled in with MINI_EX_CORE_FETCH_MISALIGN_CHK_EN.
module tb_mini_ex_core_fetch;
  import mini_ex_core_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          jmp;
  logic [31:0]   tgt;
  logic          rden;
  logic [31:0]   addr;
  logic [31:0]   rdata;
  logic          valid;
  logic [31:0]   instr;
  logic [31:0]   pc;
  t_instr_fields fields;
`ifdef MINI_EX_CORE_FETCH_MISALIGN_CHK_EN
  logic          mis;
  logic          mis_sticky;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mini_ex_core_fetch #(
    .DATA_WIDTH(32),
    .PC_RESET  (32'h0)
  ) dut (
    .Clk             (clk),
    .Rst             (rst),
    .StallQ101H      (stall),
    .JmpEnableQ101H  (jmp),
    .JmpTargetQ101H  (tgt),
    .ImemRdEnQ100H   (rden),
    .ImemAddrQ100H   (addr),
    .ImemRdDataQ101H (rdata),
    .InstrValidQ101H (valid),
    .InstrQ101H      (instr),
    .PcQ101H         (pc),
    .InstrFieldsQ101H(fields)
`ifdef MINI_EX_CORE_FETCH_MISALIGN_CHK_EN
    ,
    .MisalignQ101H      (mis),
    .MisalignStickyQ101H(mis_sticky)
`endif
  );

  // memory image: word 8 is addi x1,x0,5, others are address-tagged
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return {a[27:0], 4'h3};
  endfunction

  always @(posedge clk) begin
    if (rden) rdata <= mem_word(addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic j,
                      input logic [31:0] t);
    @(posedge clk);
    #1;
    rst   = r;
    stall = s;
    jmp   = j;
    tgt   = t;
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    jmp   = 1'b0;
    tgt   = '0;
    rdata = '0;
    #2;
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    // A: idle after reset
    tick(0, 0, 0, 0);
    chk("A_rden", 32'(rden), 32'd1);
    chk("A_addr", addr, 32'h0);
    chk("A_valid", 32'(valid), 32'd0);
    chk("A_instr", instr, 32'h13);
    chk("A_pc", pc, 32'h0);
    // B, C: streaming
    tick(0, 0, 0, 0);
    chk("B_valid", 32'(valid), 32'd1);
    chk("B_pc", pc, 32'h0);
    chk("B_instr", instr, 32'h3);
    chk("B_addr", addr, 32'h4);
    tick(0, 0, 0, 0);
    chk("C_pc", pc, 32'h4);
    chk("C_instr", instr, 32'h43);
    chk("C_addr", addr, 32'h8);
    // D, E, F: stall while presenting PC 8
    tick(0, 1, 0, 0);
    chk("D_valid", 32'(valid), 32'd1);
    chk("D_pc", pc, 32'h8);
    chk("D_instr", instr, 32'h0050_0093);
    chk("D_rden", 32'(rden), 32'd0);
    chk("D_opcode", 32'(fields.opcode), 32'h13);
    chk("D_rd", 32'(fields.rd), 32'd1);
    chk("D_rs2", 32'(fields.rs2), 32'd5);
    chk("D_func7", 32'(fields.func7), 32'd0);
    tick(0, 1, 0, 0);
    chk("E_pc", pc, 32'h8);
    chk("E_instr", instr, 32'h0050_0093);
    chk("E_rden", 32'(rden), 32'd0);
    tick(0, 1, 0, 0);
    chk("F_pc", pc, 32'h8);
    chk("F_instr", instr, 32'h0050_0093);
    chk("F_rden", 32'(rden), 32'd0);
    // G: release, held instruction consumed, read of C issued
    tick(0, 0, 0, 0);
    chk("G_valid", 32'(valid), 32'd1);
    chk("G_pc", pc, 32'h8);
    chk("G_rden", 32'(rden), 32'd1);
    chk("G_addr", addr, 32'hC);
    tick(0, 0, 0, 0);
    chk("H_pc", pc, 32'hC);
    chk("H_instr", instr, 32'hC3);
    chk("H_addr", addr, 32'h10);
    // I: jump to 0x100 while PC 0x10 is presented
    tick(0, 0, 1, 32'h100);
    chk("I_valid", 32'(valid), 32'd0);
    chk("I_instr", instr, 32'h13);
    chk("I_addr", addr, 32'h100);
    chk("I_rden", 32'(rden), 32'd1);
    // J: target valid; stall to enter hold
    tick(0, 1, 0, 0);
    chk("J_valid", 32'(valid), 32'd1);
    chk("J_pc", pc, 32'h100);
    chk("J_instr", instr, 32'h1003);
    chk("J_rden", 32'(rden), 32'd0);
    // K: jump and stall together in hold
    tick(0, 1, 1, 32'h200);
    chk("K_valid", 32'(valid), 32'd0);
    chk("K_addr", addr, 32'h200);
    chk("K_rden", 32'(rden), 32'd1);
    tick(0, 1, 0, 0);
    chk("L_valid", 32'(valid), 32'd1);
    chk("L_pc", pc, 32'h200);
    chk("L_instr", instr, 32'h2003);
    chk("L_rden", 32'(rden), 32'd0);
    tick(0, 0, 0, 0);
    chk("M_pc", pc, 32'h200);
    chk("M_instr", instr, 32'h2003);
    chk("M_addr", addr, 32'h204);
    // N, O: PC wrap
    tick(0, 0, 1, 32'hFFFF_FFFC);
    chk("N_addr", addr, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    chk("O_pc", pc, 32'hFFFF_FFFC);
    chk("O_instr", instr, 32'hFFFF_FFC3);
    chk("O_addr", addr, 32'h0);
    // P: reset mid-stream
    tick(1, 0, 0, 0);
    chk("P_rden", 32'(rden), 32'd0);
    chk("P_valid", 32'(valid), 32'd0);
    tick(0, 0, 0, 0);
    chk("Q_valid", 32'(valid), 32'd0);
    chk("Q_addr", addr, 32'h0);
    chk("Q_rden", 32'(rden), 32'd1);
    // R: misaligned jump target is masked
    tick(0, 0, 1, 32'h102);
    chk("R_addr", addr, 32'h100);
    chk("R_valid", 32'(valid), 32'd0);
`ifdef MINI_EX_CORE_FETCH_MISALIGN_CHK_EN
    chk("R_mis", 32'(mis), 32'd1);
`endif
    tick(0, 0, 0, 0);
    chk("S_pc", pc, 32'h100);
    chk("S_valid", 32'(valid), 32'd1);
    chk("S_addr", addr, 32'h104);
`ifdef MINI_EX_CORE_FETCH_MISALIGN_CHK_EN
    chk("S_mis", 32'(mis), 32'd0);
    chk("S_sticky", 32'(mis_sticky), 32'd1);
    tick(0, 0, 0, 0);
    chk("T_sticky", 32'(mis_sticky), 32'd1);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("U_sticky", 32'(mis_sticky), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
